// File: rtl/mul_share_pkg.sv
// Shared defaults, tag/product types and the tag-width helper for the multiplier-sharing scheduler.
package mul_share_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 8;
   localparam int LAT_DEF  = 2;

   // A single requester still needs a one-bit tag so vector widths stay legal.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int TAGW = tag_width(NREQ_DEF);

   typedef logic [TAGW-1:0]    tag_t;
   typedef logic [2*W_DEF-1:0] prod_t;

endpackage

// File: rtl/mul_share_sched_rr_arbiter.sv
// Round-robin pick: first eligible requester at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int TW   = 2
) (
   input  logic [NREQ-1:0] elig,
   input  logic [TW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [TW-1:0]   idx,
   output logic            any
);

   // Scan every offset from the pointer; only the first eligible index is granted.
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int off = 0; off < NREQ; off++) begin
         j = int'(ptr) + off;
         j = (j >= NREQ) ? (j - NREQ) : j;
         if (!any && elig[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = TW'(j);
         end else begin
            grant[j] = grant[j];
         end
      end
   end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one fixed-latency pipelined multiplier among NREQ valid/ready requesters,
// routing each product back to its issuer through a tag pipeline aligned with mul_p.
module mul_share_sched
   import mul_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int LAT  = LAT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   output logic [2*W-1:0]    resp_data,
   output logic              mul_start,
   output logic [W-1:0]      mul_a,
   output logic [W-1:0]      mul_b,
   input  logic [2*W-1:0]    mul_p,
   output logic              idle
);

   localparam int TW = tag_width(NREQ);

   logic [NREQ-1:0]        elig_s, grant_s;
   logic [TW-1:0]          gidx_s;
   logic                   gany_s;

   logic [NREQ-1:0]        pend_q, pend_d;
   logic [TW-1:0]          rr_ptr_q, rr_ptr_d;
   logic                   mul_start_q, mul_start_d;
   logic [W-1:0]           mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [TW-1:0]          tag_q, tag_d;
   logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
   logic [LAT-1:0][TW-1:0] pipe_tag_q, pipe_tag_d;
   logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
   logic [2*W-1:0]         resp_data_q, resp_data_d;

   assign elig_s = req_valid & ~pend_q & {NREQ{en}};

   rr_arbiter #(.NREQ(NREQ), .TW(TW)) u_arb (
      .elig  (elig_s),
      .ptr   (rr_ptr_q),
      .grant (grant_s),
      .idx   (gidx_s),
      .any   (gany_s)
   );

   // Issue, tag tracking and response capture.
   always_comb begin
      pend_d       = pend_q;
      rr_ptr_d     = rr_ptr_q;
      mul_start_d  = gany_s;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      tag_d        = tag_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;

      // The tag pipe starts one cycle after issue so its last stage lines up with mul_p.
      pipe_vld_d[0] = mul_start_q;
      pipe_tag_d[0] = tag_q;
      for (int i = 1; i < LAT; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_tag_d[i] = pipe_tag_q[i-1];
      end

      if (pipe_vld_q[LAT-1]) begin
         pend_d[pipe_tag_q[LAT-1]]       = 1'b0;
         resp_valid_d[pipe_tag_q[LAT-1]] = 1'b1;
         resp_data_d                     = mul_p;
      end else begin
         resp_data_d = resp_data_q;
      end

      if (gany_s) begin
         pend_d   = pend_d | grant_s;
         rr_ptr_d = (int'(gidx_s) == NREQ - 1) ? '0 : gidx_s + TW'(1);
         mul_a_d  = req_a[int'(gidx_s)*W +: W];
         mul_b_d  = req_b[int'(gidx_s)*W +: W];
         tag_d    = gidx_s;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // State register; reset drops everything in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend_q       <= '0;
         rr_ptr_q     <= '0;
         mul_start_q  <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         tag_q        <= '0;
         pipe_vld_q   <= '0;
         pipe_tag_q   <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         pend_q       <= pend_d;
         rr_ptr_q     <= rr_ptr_d;
         mul_start_q  <= mul_start_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         tag_q        <= tag_d;
         pipe_vld_q   <= pipe_vld_d;
         pipe_tag_q   <= pipe_tag_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready  = grant_s;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign mul_start  = mul_start_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign idle       = ~(|pend_q) & ~(|pipe_vld_q) & ~mul_start_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Randomized and directed bench for mul_share_sched against a cycle-level transaction model
// (per-requester busy-until cycle, in-flight queue of expected products).
module tb_mul_share_sched;
   import mul_share_pkg::*;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int LAT  = 2;
   localparam int RLAT = LAT + 2;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           en  = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready, resp_valid;
   logic [2*W-1:0] resp_data, mul_p;
   logic           mul_start, idle;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] p1_q = '0;
   logic [2*W-1:0] p2_q = '0;

   mul_share_sched dut (
      .CLK(CLK), .RST(RST), .en(en),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .idle(idle)
   );

   always #5 CLK = ~CLK;

   // Two-stage registered multiplier.
   always @(posedge CLK) begin
      p1_q <= {8'd0, mul_a} * {8'd0, mul_b};
      p2_q <= p1_q;
   end
   assign mul_p = p2_q;

   typedef struct {
      int    tag;
      prod_t prod;
      int    due;
   } fl_t;

   fl_t          fl_q[$];
   int           pend_until[N];
   int           rr = 0;
   int           cyc = 0;
   bit           start_exp = 1'b0;
   logic [W-1:0] a_exp = '0;
   logic [W-1:0] b_exp = '0;
   prod_t        last_data = '0;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic en_i, input logic [N-1:0] v_i,
                       input logic [N*W-1:0] a_i, input logic [N*W-1:0] b_i);
      int           g;
      logic [N-1:0] rdy_exp, rv_exp;
      logic         idle_exp;
      logic [W-1:0] ea, eb;
      @(negedge CLK);
      RST = 1'b0; en = en_i; req_valid = v_i; req_a = a_i; req_b = b_i;
      #1;
      g = -1;
      if (en_i) begin
         for (int o = 0; o < N; o++) begin
            int j;
            j = (rr + o) % N;
            if (g < 0 && v_i[j] && cyc >= pend_until[j]) g = j;
         end
      end
      rdy_exp = '0;
      if (g >= 0) rdy_exp[g] = 1'b1;
      rv_exp = '0;
      if (fl_q.size() > 0 && fl_q[0].due == cyc) begin
         rv_exp[fl_q[0].tag] = 1'b1;
         last_data = fl_q[0].prod;
         void'(fl_q.pop_front());
      end
      idle_exp = 1'b1;
      for (int k = 0; k < N; k++) if (pend_until[k] > cyc) idle_exp = 1'b0;

      check_eq("req_ready", 32'(req_ready), 32'(rdy_exp));
      check_eq("resp_valid", 32'(resp_valid), 32'(rv_exp));
      check_eq("resp_data", 32'(resp_data), 32'(last_data));
      check_eq("mul_start", 32'(mul_start), 32'(start_exp));
      check_eq("idle", 32'(idle), 32'(idle_exp));
      if (start_exp) begin
         check_eq("mul_a", 32'(mul_a), 32'(a_exp));
         check_eq("mul_b", 32'(mul_b), 32'(b_exp));
      end

      if (g >= 0) begin
         ea = a_i[g*W +: W];
         eb = b_i[g*W +: W];
         pend_until[g] = cyc + RLAT;
         fl_q.push_back('{g, prod_t'(int'(ea) * int'(eb)), cyc + RLAT});
         rr = (g + 1) % N;
         start_exp = 1'b1;
         a_exp = ea;
         b_exp = eb;
      end else begin
         start_exp = 1'b0;
      end
      cyc++;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_data", 32'(resp_data), 32'd0);
      check_eq("rst_mul_start", 32'(mul_start), 32'd0);
      check_eq("rst_mul_a", 32'(mul_a), 32'd0);
      check_eq("rst_idle", 32'(idle), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; req_valid = '0;
      #1;
      check_reset_outputs();
      fl_q.delete();
      for (int k = 0; k < N; k++) pend_until[k] = 0;
      rr = 0; start_exp = 1'b0; last_data = '0;
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 4'b0000, '0, '0);
   endtask

   initial begin
      for (int k = 0; k < N; k++) pend_until[k] = 0;
      #1;
      check_reset_outputs();
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge CLK);

      // Single request 3*5.
      step(1'b1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5});
      idle_steps(6);

      // All four at once: grants in order, products 10..40.
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd10}});
      idle_steps(6);

      // req0 and req2 held: alternation and regrant in the response cycle.
      for (int i = 0; i < 12; i++)
         step(1'b1, 4'b0101, {8'd9, 8'd7, 8'd6, 8'd11}, {8'd2, 8'd3, 8'd4, 8'd5});
      idle_steps(6);

      // Enable low blocks grants; raising it grants the same cycle.
      for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, {8'd0, 8'd0, 8'd12, 8'd0}, {8'd0, 8'd0, 8'd13, 8'd0});
      step(1'b1, 4'b0010, {8'd0, 8'd0, 8'd12, 8'd0}, {8'd0, 8'd0, 8'd13, 8'd0});
      // req1 kept valid across its own response.
      for (int i = 0; i < 7; i++) step(1'b1, 4'b0010, {8'd0, 8'd0, 8'd21, 8'd0}, {8'd0, 8'd0, 8'd3, 8'd0});
      idle_steps(6);

      // Reset with two operations in flight, then a full-scale product.
      step(1'b1, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd8}, {8'd0, 8'd0, 8'd9, 8'd10});
      step(1'b1, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd8}, {8'd0, 8'd0, 8'd9, 8'd10});
      do_reset();
      idle_steps(2);
      step(1'b1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255});
      idle_steps(6);

      // Random traffic with occasional enable drops and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom);
         end
      end
      idle_steps(8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined multiplier datapath among NREQ requesters, for example an r8_mb8-class 8x8 unit.
- Each requester uses valid/ready issue and gets a one-cycle response pulse with the product.
- Tracks in-flight operations with a tag pipeline so results return to the right requester.
- Sits in user_project_wrapper between LA/Wishbone-facing logic and the shared multiplier.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width; product is 2W
LAT, 2, multiplier latency in cycles from mul_start to valid mul_p (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
en  in  1  scheduler enable; when low, no new grants are issued
req_valid  in  NREQ  per-requester request
req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
req_ready  out  NREQ  grant/handshake strobe, combinational, one-hot or zero
resp_valid  out  NREQ  one-cycle result pulse, registered, one-hot or zero
resp_data  out  2W  product for the requester flagged in resp_valid, registered
mul_start  out  1  operand-valid strobe to the multiplier, registered
mul_a  out  W  multiplier operand A, registered
mul_b  out  W  multiplier operand B, registered
mul_p  in  2W  multiplier product, valid LAT cycles after mul_start
idle  out  1  high when nothing is pending or in flight

Behaviour:
- Reset values:
  - all registered outputs 0, idle=1
  - pend[] = 0, rr_ptr = 0, tag pipeline cleared
- Eligibility: requester i is eligible when req_valid[i] && !pend[i] && en. pend is registered.
- Arbitration:
  - Scan from rr_ptr upward, modulo NREQ; the first eligible requester g wins.
  - req_ready[g]=1 in the same cycle. A handshake is valid&&ready.
  - At most one grant per cycle.
- On a handshake at edge t:
  - mul_a/mul_b latch req_a/req_b of g, and mul_start=1 during cycle t+1.
  - pend[g] is set.
  - rr_ptr = (g+1) mod NREQ.
  - With no grant, rr_ptr holds and mul_start=0.
- Tag pipeline: a {valid, tag} shift register LAT stages deep, fed alongside mul_start. Its output stage aligns with mul_p.
- Response, when the output stage is valid with tag k:
  - Next edge registers resp_data=mul_p and resp_valid[k]=1 for one cycle.
  - pend[k] is cleared on that same edge.
- Latency: handshake at cycle t gives resp_valid at cycle t+LAT+2.
- Throughput: one issue per cycle across requesters. Each requester has at most one outstanding operation.
- Same-cycle clear and request: req_ready[k] can assert no earlier than the cycle in which resp_valid[k] is high. There is no bypass.
- resp_data holds its last value when no response is pulsing.
- en low: grants stop immediately and in-flight operations still complete and respond. rr_ptr is held.
- Requester drops valid without a handshake: no effect, operands need not be held.
- RST mid-operation:
  - all state cleared asynchronously and in-flight results discarded
  - no resp_valid for operations issued before reset
- idle = !(|pend) && !(|tag-pipe valids) && !mul_start.

Decomposition:
- Shared package mul_share_pkg:
  - NREQ/W/LAT defaults
  - localparam TAGW = clog2(NREQ)
  - typedef for tag, product type
- One sub-module, rr_arbiter: NREQ-wide round-robin pick with pointer input, producing one-hot grant and encoded index.
- Tag pipeline and pend tracking stay in the top.

Test Plan:
(NREQ=4, W=8, LAT=2; the bench models the multiplier as a 2-stage registered multiply.)
1. req0 A=3,B=5 valid at cycle t, en=1 -> req_ready[0] at t; mul_start with 3/5 at t+1; resp_valid=0001, resp_data=15 at t+4; idle=1 at t+5.
2. All four valid at t with A=i+1, B=10 -> grants 0,1,2,3 at t..t+3; resp_valid 0001,0010,0100,1000 at t+4..t+7 with data 10,20,30,40.
3. req0 and req2 held valid continuously -> grants 0,2, then req0 regrants exactly in its response cycle; req2 never starved.
4. en=0 with req1 valid for 5 cycles -> req_ready stays 0, no mul_start; raise en -> req_ready[1] the same cycle.
5. Two operations in flight, assert RST for 1 cycle -> all outputs 0, idle=1, no resp_valid afterward; a new request 2 cycles after reset completes normally (A=255, B=255 -> 65025).
6. Response for req1 coincides with req1 valid -> req_ready[1]=0 before resp_valid[1]; asserted alongside resp_valid[1] and not earlier.
